// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: two-entry elastic pipeline register with valid/ready
// handshakes and a registered in_ready for a timing-clean ready path.
module skid_pipe_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   // State encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             ready_q, ready_d;
   logic             accept;
   logic             pop;

   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign in_ready  = ready_q;
   assign count     = state_q;

   assign accept = in_valid & ready_q;
   assign pop    = out_valid & out_ready;

   // Next-state, datapath and next-ready selection; flush wipes everything.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (accept && pop) begin
               main_d  = in_data;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
      ready_d = (state_d != FULL);
   end

   // State and data registers; reset holds in_ready low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

endmodule

// File: doc/skid_pipe_reg.md
Name: skid_pipe_reg

Overview:
- Two-entry elastic pipeline register with a valid/ready handshake on both sides.
- Replaces enable-based flop stages wherever the downstream stage must apply backpressure.
- The downstream stage throttles the upstream stage through in_ready, instead of the upstream stage pushing data with an enable.
- Sits between decode pipeline stages. Sustains one transfer per cycle, and in_ready is driven from a register so the ready path is timing-clean.

Parameters:
WIDTH, 32, data word width in bits

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous reset, active-low (asserted when 0)
flush  input  1  synchronous clear of all stored entries, active-high
in_valid  input  1  upstream presents in_data
in_ready  output  1  block can accept a word this cycle; registered output
in_data  input  WIDTH  upstream data word
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  oldest stored word
count  output  2  occupancy, 0..2

Behaviour:
- Transfer rules:
  - Input transfer (accept) = in_valid & in_ready at posedge.
  - Output transfer (pop) = out_valid & out_ready at posedge.
- Storage:
  - Main register (main_q, main_v) drives out_data/out_valid directly.
  - Skid register (skid_q, skid_v) holds one overflow word.
- States, with count = number of valid entries:
  - EMPTY (0): out_valid=0, in_ready=1.
  - ONE (1): main valid, out_valid=1, in_ready=1.
  - FULL (2): main and skid valid, out_valid=1, in_ready=0.
- Transitions at posedge:
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE:
    - accept & !pop -> FULL, skid<=in_data.
    - accept & pop -> ONE, main<=in_data.
    - !accept & pop -> EMPTY.
    - else hold.
  - FULL: accept is impossible (in_ready=0).
    - pop -> ONE, main<=skid.
    - else hold.
- in_ready is registered: next in_ready = (next state != FULL). It never depends combinationally on out_ready.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N (1 cycle). Throughput is 1 word/cycle with out_ready held high.
- Ordering: strict FIFO. Data is never dropped or duplicated. out_data stays stable while out_valid=1 and out_ready=0.
- Reset (reset==0 at posedge):
  - Both valid bits cleared, main_q and skid_q cleared to 0.
  - Outputs: out_valid=0, out_data=0, count=0.
  - in_ready=0 while reset is asserted; in_ready=1 on the first cycle after release.
  - A reset mid-transfer discards both entries. An in_valid present during reset is not accepted.
- flush (reset deasserted, flush=1 at posedge):
  - Same clearing as reset, except in_ready=1 next cycle.
  - flush overrides a simultaneous accept and pop: the accepted word is dropped, and the pop is counted by downstream only.
- reset has priority over flush.
- Unknown-free: out_data is 0 whenever out_valid=0 after reset/flush, until the first accept.
- count equals main_v + skid_v, registered, consistent with out_valid/in_ready every cycle.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> in_ready=0, out_valid=0, out_data=0, count=0. First cycle after release: in_ready=1, count=0.
- Streaming: out_ready=1, send 0x11,0x22,0x33,0x44 on consecutive cycles -> out_data shows 0x11..0x44 on 4 consecutive cycles, each 1 cycle after its accept. count stays 1, in_ready stays 1.
- Backpressure fill: out_ready=0, offer 0xA1,0xA2,0xA3 -> 0xA1 and 0xA2 accepted, count=2, in_ready=0. 0xA3 held by upstream, out_data=0xA1 stable.
- Drain and ordering: from FULL (0xA1,0xA2), raise out_ready with 0xA3 still offered -> pops 0xA1, then 0xA2, then 0xA3 in order. No loss, no duplicate. in_ready returns to 1 the cycle after the first pop.
- Simultaneous accept/pop in ONE: main=0x55, in_data=0x66, in_valid=out_ready=1 -> next cycle out_data=0x66, count=1.
- Flush and reset priority:
  - In FULL, assert flush with in_valid=1 -> count=0, out_valid=0, in_ready=1 next cycle, input word dropped.
  - Repeat with reset=0 and flush=1 together -> in_ready=0 (reset wins).
